// File: rtl/fp_pkg.sv
// Shared FP32 constants, inter-stage bundles and helpers
// for the pipelined single-precision adder.
package fp_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int LAT   = 4;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] PINF = 32'h7F80_0000;

  typedef struct packed {
    logic             spec;
    logic [FP_W-1:0]  sval;
    logic             inv;
    logic             sign;
    logic             esub;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mb;
    logic [MAN_W:0]   ms;
    logic [EXP_W-1:0] diff;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [FP_W-1:0]  sval;
    logic             inv;
    logic             sign;
    logic             esub;
    logic [EXP_W-1:0] exp;
    logic [26:0]      mb;
    logic [26:0]      ms;
  } s2_t;

  typedef struct packed {
    logic             spec;
    logic [FP_W-1:0]  sval;
    logic             inv;
    logic             sign;
    logic             zero;
    logic [9:0]       exp;
    logic [26:0]      man;
  } s3_t;

  function automatic logic [4:0] lzc27(
    input logic [26:0] v
  );
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

endpackage

// File: rtl/fp_add_lane.sv
// One FP32 adder lane: unpack/swap, align, add/normalise,
// round/pack, each stage held by ena and wiped by clr.
module fp_add_lane
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            clr,
  input  logic [FP_W-1:0] i_a,
  input  logic [FP_W-1:0] i_b,
  input  logic            i_sub,
  input  logic            i_v3,
  output logic [FP_W-1:0] o_res,
  output logic            o_ovf,
  output logic            o_inv
);

  s1_t r_s1, w_s1;
  s2_t r_s2, w_s2;
  s3_t r_s3, w_s3;

  logic [FP_W-1:0] r_res, w_res;
  logic            r_ovf, w_ovf;
  logic            r_inv, w_inv;

  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic [MAN_W:0]   w_ma, w_mb;
  logic             w_za, w_zb;
  logic             w_ia, w_ib;
  logic             w_na, w_nb;
  logic             w_agb;

  assign w_sa = i_a[31];
  assign w_ea = i_a[30:23];
  assign w_fa = i_a[22:0];
  assign w_sb = i_b[31] ^ i_sub;
  assign w_eb = i_b[30:23];
  assign w_fb = i_b[22:0];

  // Denormals flush to signed zero here
  assign w_za = (w_ea == '0);
  assign w_zb = (w_eb == '0);
  assign w_ia = (w_ea == '1) && (w_fa == '0);
  assign w_ib = (w_eb == '1) && (w_fb == '0);
  assign w_na = (w_ea == '1) && (w_fa != '0);
  assign w_nb = (w_eb == '1) && (w_fb != '0);
  assign w_ma = w_za ? '0 : {1'b1, w_fa};
  assign w_mb = w_zb ? '0 : {1'b1, w_fb};
  assign w_agb = {w_ea, w_ma} >= {w_eb, w_mb};

  always_comb begin
    w_s1      = '0;
    w_s1.sign = w_agb ? w_sa : w_sb;
    w_s1.esub = w_sa ^ w_sb;
    w_s1.exp  = w_agb ? w_ea : w_eb;
    w_s1.mb   = w_agb ? w_ma : w_mb;
    w_s1.ms   = w_agb ? w_mb : w_ma;
    w_s1.diff = w_agb ? w_ea - w_eb : w_eb - w_ea;
    if (w_na | w_nb) begin
      w_s1.spec = 1'b1;
      w_s1.sval = QNAN;
    end else if (w_ia & w_ib) begin
      w_s1.spec = 1'b1;
      w_s1.inv  = w_sa ^ w_sb;
      w_s1.sval = (w_sa ^ w_sb) ? QNAN
                                : {w_sa, PINF[30:0]};
    end else if (w_ia) begin
      w_s1.spec = 1'b1;
      w_s1.sval = {w_sa, PINF[30:0]};
    end else if (w_ib) begin
      w_s1.spec = 1'b1;
      w_s1.sval = {w_sb, PINF[30:0]};
    end else if (w_za & w_zb) begin
      w_s1.spec = 1'b1;
      w_s1.sval = {w_sa & w_sb, 31'd0};
    end
  end

  logic [26:0] w_full, w_sh;
  logic        w_stk;

  always_comb begin
    w_s2      = '0;
    w_s2.spec = r_s1.spec;
    w_s2.sval = r_s1.sval;
    w_s2.inv  = r_s1.inv;
    w_s2.sign = r_s1.sign;
    w_s2.esub = r_s1.esub;
    w_s2.exp  = r_s1.exp;
    w_s2.mb   = {r_s1.mb, 3'b000};
    w_full    = {r_s1.ms, 3'b000};
    w_sh      = w_full >> r_s1.diff;
    w_stk     = |(w_full & ((27'd1 << r_s1.diff) - 27'd1));
    if (r_s1.diff >= 8'd27)
      w_s2.ms = {26'd0, |r_s1.ms};
    else
      w_s2.ms = {w_sh[26:1], w_sh[0] | w_stk};
  end

  logic [27:0] w_sum;
  logic [4:0]  w_lz;

  always_comb begin
    w_s3      = '0;
    w_s3.spec = r_s2.spec;
    w_s3.sval = r_s2.sval;
    w_s3.inv  = r_s2.inv;
    w_s3.sign = r_s2.sign;
    w_sum     = r_s2.esub ? {1'b0, r_s2.mb} - {1'b0, r_s2.ms}
                          : {1'b0, r_s2.mb} + {1'b0, r_s2.ms};
    w_lz      = lzc27(w_sum[26:0]);
    w_s3.zero = (w_sum == '0);
    if (w_sum[27]) begin
      w_s3.man = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_s3.exp = {2'b00, r_s2.exp} + 10'd1;
    end else begin
      w_s3.man = w_sum[26:0] << w_lz;
      w_s3.exp = {2'b00, r_s2.exp} - {5'd0, w_lz};
    end
  end

  logic        w_up;
  logic [24:0] w_m;
  logic [9:0]  w_e;

  always_comb begin
    w_up  = r_s3.man[2] &
            (r_s3.man[1] | r_s3.man[0] | r_s3.man[3]);
    w_m   = {1'b0, r_s3.man[26:3]} + {24'd0, w_up};
    w_e   = r_s3.exp + {9'd0, w_m[24]};
    w_res = '0;
    w_ovf = 1'b0;
    w_inv = 1'b0;
    if (r_s3.spec) begin
      w_res = r_s3.sval;
      w_inv = r_s3.inv;
    end else if (r_s3.zero || r_s3.exp[9] ||
                 r_s3.exp == '0) begin
      w_res = '0;
    end else if (w_e >= 10'd255) begin
      w_res = {r_s3.sign, PINF[30:0]};
      w_ovf = 1'b1;
    end else begin
      w_res = {r_s3.sign, w_e[7:0],
               w_m[24] ? w_m[23:1] : w_m[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_res <= '0;
      r_ovf <= 1'b0;
      r_inv <= 1'b0;
    end else if (clr) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_res <= '0;
      r_ovf <= 1'b0;
      r_inv <= 1'b0;
    end else if (ena) begin
      r_s1  <= w_s1;
      r_s2  <= w_s2;
      r_s3  <= w_s3;
      r_res <= i_v3 ? w_res : '0;
      r_ovf <= i_v3 & w_ovf;
      r_inv <= i_v3 & w_inv;
    end
  end

  assign o_res = r_res;
  assign o_ovf = r_ovf;
  assign o_inv = r_inv;

endmodule

// File: rtl/fp_add_pipe.sv
// Multi-lane pipelined FP32 adder: valid tracking and
// port packing around LANES independent lane datapaths.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int SUB_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [FP_W*LANES-1:0] ax,
  input  logic [FP_W*LANES-1:0] ay,
  input  logic [LANES-1:0]      sub,
  output logic                  out_valid,
  output logic [FP_W*LANES-1:0] result,
  output logic [LANES-1:0]      overflow,
  output logic [LANES-1:0]      invalid
);

  logic [LAT-1:0]   r_vld;
  logic [LANES-1:0] w_sub;

  assign w_sub = (SUB_EN != 0) ? sub : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_vld <= '0;
    else if (clr)
      r_vld <= '0;
    else if (ena)
      r_vld <= {r_vld[LAT-2:0], in_valid};
  end

  assign out_valid = r_vld[LAT-1];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_add_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .clr   (clr),
      .i_a   (ax[FP_W*g +: FP_W]),
      .i_b   (ay[FP_W*g +: FP_W]),
      .i_sub (w_sub[g]),
      .i_v3  (r_vld[LAT-2]),
      .o_res (result[FP_W*g +: FP_W]),
      .o_ovf (overflow[g]),
      .o_inv (invalid[g])
    );
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Randomised scoreboard bench for fp_add_pipe (4 lanes)
// against an exact wide-integer reference model.
module tb_fp_add_pipe;
  import fp_pkg::*;

  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           ena = 1'b0;
  logic           clr = 1'b0;
  logic           in_valid = 1'b0;
  logic [32*L-1:0] ax = '0;
  logic [32*L-1:0] ay = '0;
  logic [L-1:0]   sub = '0;
  logic           out_valid;
  logic [32*L-1:0] result;
  logic [L-1:0]   overflow;
  logic [L-1:0]   invalid;

  fp_add_pipe #(.LANES(L), .SUB_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clr       (clr),
    .in_valid  (in_valid),
    .ax        (ax),
    .ay        (ay),
    .sub       (sub),
    .out_valid (out_valid),
    .result    (result),
    .overflow  (overflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [32*L-1:0] res;
    logic [L-1:0]    ovf;
    logic [L-1:0]    inv;
    logic [31:0]     idx;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          en_cnt = 0;
  bit          adv = 1'b0;
  bit          dir_en = 1'b0;
  logic [33:0] dir_exp = '0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Exact sum as an integer in units of 2^-150, then RNE.
  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b0,
                                        input logic s);
    logic [31:0] b;
    logic sa, sb, sg;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic signed [299:0] va, vb, sm;
    logic [299:0] mag, rem, half, top;
    int p, e;
    b = b0 ^ {s, 31'd0};
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0))
      return {2'b00, QNAN};
    if (ea == 8'hFF && eb == 8'hFF)
      return (sa != sb) ? {2'b01, QNAN} : {2'b00, sa, PINF[30:0]};
    if (ea == 8'hFF) return {2'b00, sa, PINF[30:0]};
    if (eb == 8'hFF) return {2'b00, sb, PINF[30:0]};
    if (ea == 0 && eb == 0) return {2'b00, sa & sb, 31'd0};
    va = (ea == 0) ? '0 : $signed({276'd0, 1'b1, fa} << ea);
    vb = (eb == 0) ? '0 : $signed({276'd0, 1'b1, fb} << eb);
    if (sa) va = -va;
    if (sb) vb = -vb;
    sm = va + vb;
    if (sm == 0) return 34'd0;
    sg = (sm < 0);
    mag = sg ? -sm : sm;
    p = 0;
    for (int i = 0; i < 300; i++)
      if (mag[i]) p = i;
    e = p - 23;
    if (e <= 0) return 34'd0;
    top = mag >> e;
    rem = mag & ((300'd1 << e) - 300'd1);
    half = 300'd1 << (e - 1);
    if (rem > half || (rem == half && top[0])) top = top + 1;
    if (top[24]) begin
      top = top >> 1;
      e++;
    end
    if (e >= 255) return {2'b10, sg, PINF[30:0]};
    return {2'b00, sg, e[7:0], top[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] r);
    int c, e;
    logic sg;
    logic [22:0] f;
    c = $urandom_range(0, 19);
    sg = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    e = int'(r[30:23]) + int'($urandom_range(0, 4)) - 2;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    if (c == 0) return {sg, 31'd0};
    if (c == 1) return {sg, 8'h00, f};
    if (c == 2) return {sg, 8'hFF, 23'd0};
    if (c == 3) return {sg, 8'hFF, f | 23'd1};
    if (c == 4) return {sg, 8'hFE, f};
    if (c < 12) return {sg, 8'(e), r[22:0] ^ (f & 23'h1F)};
    return {sg, 8'($urandom_range(1, 254)), f};
  endfunction

  // Scoreboard push on every accepting edge
  initial begin
    exp_t x;
    logic [33:0] m;
    forever begin
      @(posedge clk);
      if (rst_n && !clr && ena) begin
        en_cnt++;
        adv = 1'b1;
        if (in_valid) begin
          x = '0;
          x.idx = 32'(en_cnt);
          for (int i = 0; i < L; i++) begin
            m = model(ax[32*i +: 32], ay[32*i +: 32], sub[i]);
            if (i == 0 && dir_en) m = dir_exp;
            x.res[32*i +: 32] = m[31:0];
            x.inv[i] = m[32];
            x.ovf[i] = m[33];
          end
          q.push_back(x);
        end
      end else begin
        adv = 1'b0;
      end
    end
  end

  // Monitor: one pop per freshly produced output
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && adv && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 128'(out_valid), 128'd0);
        end else begin
          e = q.pop_front();
          for (int i = 0; i < L; i++)
            chk($sformatf("lane%0d_out", i),
                {overflow[i], invalid[i], result[32*i +: 32]},
                {e.ovf[i], e.inv[i], e.res[32*i +: 32]});
          chk("latency", 32'(en_cnt) - e.idx, 3);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_inputs();
    logic [31:0] a, b;
    for (int i = 0; i < L; i++) begin
      a = rnd_op($urandom);
      b = rnd_op(a);
      ax[32*i +: 32] = a;
      ay[32*i +: 32] = b;
      sub[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_dir(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [33:0] ex);
    rand_inputs();
    ax[31:0] = a;
    ay[31:0] = b;
    sub[0] = s;
    dir_en = 1'b1;
    dir_exp = ex;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dir_en = 1'b0;
  endtask

  task automatic send_rand();
    rand_inputs();
    in_valid = 1'b1;
    step();
  endtask

  task automatic drain();
    int k;
    ena = 1'b1;
    in_valid = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      step();
      k++;
    end
    chk("drain_left", 128'(q.size()), 128'd0);
    repeat (6) step();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_vld"}, 128'(out_valid), 128'd0);
    chk({nm, "_res"}, 128'(result), 128'd0);
    chk({nm, "_ovf"}, 128'(overflow), 128'd0);
    chk({nm, "_inv"}, 128'(invalid), 128'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ena = 1'b1;

    send_dir(32'h3F800000, 32'h40000000, 1'b0, {2'b00, 32'h40400000});
    send_dir(32'h3F800000, 32'h3F800000, 1'b1, {2'b00, 32'h00000000});
    send_dir(32'h80000000, 32'h80000000, 1'b0, {2'b00, 32'h80000000});
    send_dir(32'h7F800000, 32'hFF800000, 1'b0, {2'b01, 32'h7FC00000});
    send_dir(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {2'b10, 32'h7F800000});
    send_dir(32'h3F800000, 32'h33800000, 1'b0, {2'b00, 32'h3F800000});
    send_dir(32'h3F800001, 32'h33800000, 1'b0, {2'b00, 32'h3F800002});
    send_dir(32'h7F800000, 32'h7F800000, 1'b1, {2'b01, 32'h7FC00000});
    send_dir(32'h00400000, 32'h3F800000, 1'b0, {2'b00, 32'h3F800000});
    send_dir(32'hFF800000, 32'h3F800000, 1'b0, {2'b00, 32'hFF800000});

    // Mixed NaN / normal / inf-inf lanes in one set
    ax = {32'h40000000, 32'h7F800000, 32'h3F800000, 32'h7FC00001};
    ay = {32'hFFC00000, 32'h7F800000, 32'h40000000, 32'h3F800000};
    sub = 4'b0100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain();

    // Six sets with gaps and a three-cycle stall
    send_rand();
    in_valid = 1'b0;
    step();
    send_rand();
    send_rand();
    rand_inputs();
    in_valid = 1'b1;
    ena = 1'b0;
    repeat (3) step();
    ena = 1'b1;
    send_rand();
    in_valid = 1'b0;
    step();
    send_rand();
    send_rand();
    drain();

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      ena = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    // clr wins over ena=0 and in_valid=1
    send_rand();
    send_rand();
    ena = 1'b0;
    clr = 1'b1;
    step();
    chk_zero("clr");
    q.delete();
    clr = 1'b0;
    drain();

    // Reset with three sets in flight
    send_rand();
    send_rand();
    send_rand();
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    #1 chk_zero("midreset");
    step();
    step();
    rst_n = 1'b1;
    send_rand();
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter LANES, default 1, number of independent FP32 adder lanes (1..16).
REQ-002 SHALL have parameter SUB_EN, default 1; 1 = per-lane subtract control honoured, 0 = sub input ignored (always add).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ena  input  1  pipeline advance enable; 0 freezes every stage.
REQ-006 SHALL have port clr  input  1  synchronous clear of all pipeline valid bits and outputs.
REQ-007 SHALL have port in_valid  input  1  operand set valid.
REQ-008 SHALL have port ax  input  32*LANES  IEEE-754 single operand A, lane i at bits [32i+31:32i].
REQ-009 SHALL have port ay  input  32*LANES  operand B, same packing.
REQ-010 SHALL have port sub  input  LANES  per-lane: 1 = ax-ay, 0 = ax+ay.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port result  output  32*LANES  sums, same packing.
REQ-013 SHALL have ports overflow, invalid  output  LANES each  per-lane flags, qualified by out_valid.

Function
REQ-014 SHALL have fixed latency of 4 enabled cycles: a set accepted on an edge with ena=1 and in_valid=1 appears on out_valid/result after the 4th such edge.
REQ-015 SHALL implement stages: S1 unpack, special-case detect, magnitude compare/swap; S2 align smaller mantissa with guard/round/sticky; S3 add/subtract and leading-zero normalise; S4 round-to-nearest-even, exponent adjust, pack.
REQ-016 SHALL, with ena=0, hold all stage registers, out_valid and outputs unchanged; no set is lost or duplicated.
REQ-017 SHALL propagate in_valid through a 4-deep valid shift register advancing only when ena=1; bubbles are preserved.
REQ-018 SHALL, when clr=1 on an edge, clear all valid bits, result, overflow and invalid to 0, taking priority over ena and in_valid.
REQ-019 SHALL flush denormal inputs to signed zero and flush denormal results to +0.
REQ-020 SHALL output canonical NaN 0x7FC00000 for any NaN input or inf-inf of opposite effective sign; invalid=1 for inf-inf only.
REQ-021 SHALL output correctly signed infinity for inf plus finite, or inf plus like-signed inf, with no flag.
REQ-022 SHALL, on finite exponent overflow after rounding, output signed infinity and set overflow=1.
REQ-023 SHALL give exact cancellation as +0; (-0)+(-0) SHALL give -0.
REQ-024 SHALL compute lanes independently; a special case in one lane SHALL NOT affect another.

Reset
REQ-025 SHALL, while rst_n=0, force all valid bits, out_valid, result, overflow and invalid to 0 asynchronously.
REQ-026 SHALL discard in-flight sets on reset assertion mid-operation; first valid output after release is a set accepted after release.
REQ-027 SHALL accept new input on the first edge after rst_n deasserts.

Structure
REQ-028 SHALL place FP_W=32, EXP_W=8, MAN_W=23, BIAS=127, QNAN=0x7FC00000, PINF=0x7F800000 and the stage-count constant LAT=4 in shared package fp_pkg.
REQ-029 SHALL implement one lane datapath as sub-module fp_add_lane (stage registers gated by ena/clr), instantiated LANES times by generate; fp_add_pipe owns the valid shift register and port packing.

Verification
REQ-030 SHALL cover: ax=0x3F800000, ay=0x40000000, sub=0 -> result 0x40400000, out_valid exactly 4 cycles later, flags 0.
REQ-031 SHALL cover: ax=0x3F800000, ay=0x3F800000, sub=1 -> 0x00000000; ax=ay=0x80000000, sub=0 -> 0x80000000.
REQ-032 SHALL cover: ax=0x7F800000, ay=0xFF800000 -> 0x7FC00000, invalid=1; ax=ay=0x7F7FFFFF -> 0x7F800000, overflow=1.
REQ-033 SHALL cover RNE tie: ax=0x3F800000, ay=0x33800000 -> 0x3F800000; ax=0x3F800001, ay=0x33800000 -> 0x3F800002.
REQ-034 SHALL cover stall and bubbles: 6 back-to-back sets with in_valid gaps, ena low 3 cycles mid-stream -> outputs in order, gaps preserved, none lost or duplicated.
REQ-035 SHALL cover LANES=4 with mixed NaN/normal lanes, and rst_n pulsed with 3 sets in flight -> out_valid stays 0 until a post-reset set emerges 4 cycles after acceptance.
